// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single memory port with a ready/wait handshake.
module multicycle_controller #(
  parameter int ALUC_W          = 3,
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic              zero,
  input  logic              sign,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [ALUC_W-1:0] ALUControl,
  output logic [2:0]        ImmSrc,
  output logic              RegWrite,
  output logic              illegal,
  output logic              retire,
  output logic [3:0]        state
);

  // state    | meaning
  // FETCH    | read IR from memory at PC, PC <= PC+4 on ready
  // DECODE   | ALUOut <= OldPC+imm, classify instruction
  // MEMADR   | ALUOut <= rs1+imm (load/store address)
  // MEMREAD  | load access, wait for ready
  // MEMWB    | rd <= load data
  // MEMWRITE | store access, wait for ready
  // EXECR    | register-register ALU op
  // EXECI    | register-immediate ALU op
  // ALUWB    | rd <= ALUOut
  // BRANCH   | compare rs1-rs2, PC <= target when taken
  // JAL      | PC <= target, ALUOut <= OldPC+4
  // JALR     | PC <= rs1+imm
  // JALRLINK | ALUOut <= OldPC+4
  // LUI      | rd <= immediate
  // TRAP     | illegal instruction, exit only through reset
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK, S_LUI, S_TRAP
  } state_t;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  state_t r_state;
  state_t w_next;

  logic       w_ready;
  logic       w_is_lw, w_is_sw, w_is_r, w_is_i, w_is_br, w_is_jal, w_is_jalr, w_is_lui;
  logic       w_legal, w_taken;
  logic [2:0] w_alu_r, w_alu_i;
  logic       w_pcwrite, w_adrsrc, w_memwrite, w_irwrite, w_regwrite, w_illegal, w_retire;
  logic [1:0] w_resultsrc, w_srca, w_srcb;
  logic [2:0] w_alu, w_immsrc;

  assign w_ready   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign w_is_lw   = (opcode == 7'b0000011);
  assign w_is_sw   = (opcode == 7'b0100011);
  assign w_is_r    = (opcode == 7'b0110011);
  assign w_is_i    = (opcode == 7'b0010011);
  assign w_is_br   = (opcode == 7'b1100011);
  assign w_is_jal  = (opcode == 7'b1101111);
  assign w_is_jalr = (opcode == 7'b1100111);
  assign w_is_lui  = (opcode == 7'b0110111);

  always_comb begin
    w_alu_r = ALU_ADD;
    case ({func7, func3})
      {7'b0000000, 3'b000}: w_alu_r = ALU_ADD;
      {7'b0100000, 3'b000}: w_alu_r = ALU_SUB;
      {7'b0000000, 3'b010}: w_alu_r = ALU_SLT;
      {7'b0000000, 3'b011}: w_alu_r = ALU_SLTU;
      {7'b0000000, 3'b110}: w_alu_r = ALU_OR;
      {7'b0000000, 3'b111}: w_alu_r = ALU_AND;
      default:              w_alu_r = ALU_ADD;
    endcase
  end

  always_comb begin
    w_alu_i = ALU_ADD;
    case (func3)
      3'b010:  w_alu_i = ALU_SLT;
      3'b011:  w_alu_i = ALU_SLTU;
      3'b100:  w_alu_i = ALU_XOR;
      3'b110:  w_alu_i = ALU_OR;
      3'b111:  w_alu_i = ALU_AND;
      default: w_alu_i = ALU_ADD;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    if (w_is_lw || w_is_sw) w_legal = (func3 == 3'b010);
    else if (w_is_jalr)     w_legal = (func3 == 3'b000);
    else if (w_is_br)       w_legal = (func3 == 3'b000) || (func3 == 3'b001) ||
                                      (func3 == 3'b100) || (func3 == 3'b101);
    else if (w_is_r)        w_legal = ((func7 == 7'b0000000) &&
                                       ((func3 == 3'b000) || (func3 == 3'b010) ||
                                        (func3 == 3'b011) || (func3 == 3'b110) ||
                                        (func3 == 3'b111))) ||
                                      ((func7 == 7'b0100000) && (func3 == 3'b000));
    else if (w_is_i)        w_legal = (func3 != 3'b001) && (func3 != 3'b101);
    else if (w_is_jal || w_is_lui) w_legal = 1'b1;
  end

  always_comb begin
    w_taken = 1'b0;
    case (func3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = sign;
      3'b101:  w_taken = ~sign;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_immsrc = 3'b000;
    if (w_is_sw)       w_immsrc = 3'b001;
    else if (w_is_br)  w_immsrc = 3'b010;
    else if (w_is_jal) w_immsrc = 3'b011;
    else if (w_is_lui) w_immsrc = 3'b100;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_pcwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_resultsrc = 2'b00;
    w_srca      = 2'b00;
    w_srcb      = 2'b00;
    w_alu       = ALU_ADD;
    w_regwrite  = 1'b0;
    w_illegal   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_srcb      = 2'b10;
        w_resultsrc = 2'b10;
        if (w_ready) begin
          w_pcwrite = 1'b1;
          w_irwrite = 1'b1;
          w_next    = S_DECODE;
        end
      end
      S_DECODE: begin
        w_srca = 2'b01;
        w_srcb = 2'b01;
        if (!w_legal) begin
          if (TRAP_ON_ILLEGAL) w_next = S_TRAP;
          else begin
            w_next   = S_FETCH;
            w_retire = 1'b1;
          end
        end
        else if (w_is_lw || w_is_sw) w_next = S_MEMADR;
        else if (w_is_r)             w_next = S_EXECR;
        else if (w_is_i)             w_next = S_EXECI;
        else if (w_is_br)            w_next = S_BRANCH;
        else if (w_is_jal)           w_next = S_JAL;
        else if (w_is_jalr)          w_next = S_JALR;
        else                         w_next = S_LUI;
      end
      S_MEMADR: begin
        w_srca = 2'b10;
        w_srcb = 2'b01;
        w_next = w_is_sw ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adrsrc = 1'b1;
        if (w_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
        if (w_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXECR: begin
        w_srca = 2'b10;
        w_alu  = w_alu_r;
        w_next = S_ALUWB;
      end
      S_EXECI: begin
        w_srca = 2'b10;
        w_srcb = 2'b01;
        w_alu  = w_alu_i;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        w_srca    = 2'b10;
        w_alu     = ALU_SUB;
        w_pcwrite = w_taken;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      // PC takes the DECODE-time target while the ALU forms the link address
      S_JAL: begin
        w_pcwrite = 1'b1;
        w_srca    = 2'b01;
        w_srcb    = 2'b10;
        w_next    = S_ALUWB;
      end
      S_JALR: begin
        w_srca      = 2'b10;
        w_srcb      = 2'b01;
        w_resultsrc = 2'b10;
        w_pcwrite   = 1'b1;
        w_next      = S_JALRLINK;
      end
      S_JALRLINK: begin
        w_srca = 2'b01;
        w_srcb = 2'b10;
        w_next = S_ALUWB;
      end
      S_LUI: begin
        w_resultsrc = 2'b11;
        w_regwrite  = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign PCWrite    = rst_n & w_pcwrite;
  assign IRWrite    = rst_n & w_irwrite;
  assign MemWrite   = rst_n & w_memwrite;
  assign RegWrite   = rst_n & w_regwrite;
  assign retire     = rst_n & w_retire;
  assign illegal    = rst_n & w_illegal;
  assign AdrSrc     = w_adrsrc;
  assign ResultSrc  = w_resultsrc;
  assign ALUSrcA    = w_srca;
  assign ALUSrcB    = w_srcb;
  assign ALUControl = ALUC_W'(w_alu);
  assign ImmSrc     = w_immsrc;
  assign state      = r_state;

endmodule
